mipi_rx_packet_decoder: RTL
===========================

// Module: mipi_rx_packet_decoder
// PURPOSE
//  Sits between 4-lane byte aligner and mipi_rx_raw_depacker. Parses CSI-2 long
//  packet header (DI, WC, ECC) from first aligned word of each burst, then passes
//  exactly ceil(WC/4) payload words with a valid strobe and the 3-bit packet type
//  the depacker uses. Drops short packets, unsupported types, filtered VCs, trailing CRC.
// PARAMETERS
//  VC_FILTER_EN  1'b0  1: accept only packets whose DI[7:6] == VC_ID
//  VC_ID         2'd0  virtual channel accepted when VC_FILTER_EN=1
// PORTS
//  clk_i            in   1   byte clock, all logic on rising edge
//  reset_n_i        in   1   asynchronous active-low reset
//  data_valid_i     in   1   aligned lane data valid; high for whole HS burst
//  data_i           in   32  lane bytes, lane0=[7:0] .. lane3=[31:24]
//  output_valid_o   out  1   payload word valid (to depacker data_valid_i)
//  data_o           out  32  payload word, same lane ordering as data_i
//  packet_type_o    out  3   DI[2:0] of current packet (to depacker packet_type_i)
//  packet_length_o  out  16  WC of current packet, bytes
//  header_err_o     out  1   1-cycle pulse: unsupported DI or VC mismatch on header
// BEHAVIOUR
//  Reset: state=IDLE; output_valid_o=0, data_o=0, packet_type_o=0,
//   packet_length_o=0, header_err_o=0, byte remaining counter=0.
//  Header: first cycle with data_valid_i=1 while in IDLE. DI=data_i[7:0],
//   WC={data_i[23:16],data_i[15:8]}, ECC=data_i[31:24] (not checked).
//  Accepted DI[5:0]: 0x2B RAW10, 0x2C RAW12, 0x2D RAW14 only.
//  FSM:
//   IDLE    -> PAYLOAD if header accepted and WC!=0; latch packet_type_o=DI[2:0],
//              packet_length_o=WC, remaining=WC.
//           -> DRAIN if header accepted and WC==0 (no payload output).
//           -> DRAIN + header_err_o pulse if DI unsupported or VC filtered.
//   PAYLOAD each data_valid_i=1 cycle: register data_i to data_o,
//              output_valid_o=1, remaining-=4 (saturate at 0);
//              if remaining<=4 this is last word -> DRAIN.
//   DRAIN   ignore input (CRC, trail bytes) until data_valid_i=0 -> IDLE.
//  Any state: data_valid_i=0 -> IDLE next cycle; in PAYLOAD this is an abort,
//   output_valid_o drops next cycle, remaining cleared, no error flag.
//  Latency: header at cycle N; first payload word on data_i at N+1 appears on
//   data_o with output_valid_o=1 at N+2. Output fully registered, 1-cycle pipe.
//  WC not multiple of 4: last word output whole; unused upper bytes unmasked.
//  output_valid_o contiguous for ceil(WC/4) cycles; no gaps (input has none).
//  packet_type_o/packet_length_o hold from header until next accepted header;
//   stable throughout payload and after (depacker samples during data_valid=0).
//  data_o holds last value when output_valid_o=0.
//  Remaining counter 17 bits; WC=0xFFFF yields 16384 words, no wrap.
//  Reset assertion mid-packet: immediate return to reset values; next burst
//   after release parsed as fresh header.
// TESTING
//  RAW10 DI=0x2B WC=20: 5 payload words follow header -> output_valid_o high 5
//   cycles starting header+2, data_o matches words in order, packet_type_o=3'h3.
//  RAW12 DI=0x2C WC=6 + 2 CRC words -> exactly 2 valid cycles, type=3'h4,
//   packet_length_o=16'd6, CRC words never output.
//  DI=0x12 (embedded) WC=8 -> header_err_o 1 pulse at header+1, no valid output.
//  DI=0x2D WC=0 -> no valid, no error, returns IDLE when data_valid_i drops.
//  VC_FILTER_EN=1 VC_ID=1, DI=0x2B (VC0) -> dropped + err; DI=0x6B -> accepted.
//  RAW10 WC=40, data_valid_i drops after 3 payload words -> 3 valid cycles,
//   IDLE; following packet WC=8 decodes normally; reset_n_i pulse mid-payload
//   -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 long packet header parser: strips the header, forwards ceil(WC/4) payload words
// and drops short packets, unsupported data types, filtered VCs and trailing CRC bytes.
module mipi_rx_packet_decoder #(
  parameter logic       VC_FILTER_EN = 1'b0,
  parameter logic [1:0] VC_ID        = 2'd0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        output_valid_o,
  output logic [31:0] data_o,
  output logic [2:0]  packet_type_o,
  output logic [15:0] packet_length_o,
  output logic        header_err_o
);

  typedef enum logic [1:0] {StIdle, StPayload, StDrain} state_e;

  state_e      state_q, state_d;
  logic [16:0] remaining_q, remaining_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  type_q, type_d;
  logic [15:0] length_q, length_d;
  logic        err_q, err_d;

  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic        hdr_type_ok;
  logic        hdr_vc_ok;

  assign hdr_di      = data_i[7:0];
  assign hdr_wc      = data_i[23:8];
  assign hdr_type_ok = (hdr_di[5:0] == 6'h2B) || (hdr_di[5:0] == 6'h2C) ||
                       (hdr_di[5:0] == 6'h2D);
  assign hdr_vc_ok   = !VC_FILTER_EN || (hdr_di[7:6] == VC_ID);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    type_d      = type_q;
    length_d    = length_q;
    err_d       = 1'b0;

    if (!data_valid_i) begin
      // End of burst (or abort mid-payload): back to header hunting, no error.
      state_d     = StIdle;
      remaining_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (hdr_type_ok && hdr_vc_ok) begin
            type_d      = hdr_di[2:0];
            length_d    = hdr_wc;
            remaining_d = {1'b0, hdr_wc};
            state_d     = (hdr_wc != 16'd0) ? StPayload : StDrain;
          end else begin
            err_d   = 1'b1;
            state_d = StDrain;
          end
        end
        StPayload: begin
          data_d      = data_i;
          valid_d     = 1'b1;
          remaining_d = (remaining_q > 17'd4) ? (remaining_q - 17'd4) : '0;
          if (remaining_q <= 17'd4) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          state_d = StDrain;
        end
        default: begin
          state_d     = StIdle;
          remaining_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      type_q      <= '0;
      length_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      type_q      <= type_d;
      length_q    <= length_d;
      err_q       <= err_d;
    end
  end

  assign output_valid_o  = valid_q;
  assign data_o          = data_q;
  assign packet_type_o   = type_q;
  assign packet_length_o = length_q;
  assign header_err_o    = err_q;

endmodule
